// File: rtl/mac_dma_scheduler.sv
// mac_dma_scheduler: round-robin arbiter sharing one DMA control port between
// the mac accelerator read and write request streams, then gating the matching
// data channel until the granted number of beats has transferred. One
// transaction in flight at a time.
module mac_dma_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // accelerator read request
    input  logic                  acc_rd_ctrl_valid,
    input  logic [LEN_WIDTH-1:0]  acc_rd_ctrl_index,
    input  logic [LEN_WIDTH-1:0]  acc_rd_ctrl_length,
    input  logic [2:0]            acc_rd_ctrl_size,
    output logic                  acc_rd_ctrl_ready,
    // accelerator write request
    input  logic                  acc_wr_ctrl_valid,
    input  logic [LEN_WIDTH-1:0]  acc_wr_ctrl_index,
    input  logic [LEN_WIDTH-1:0]  acc_wr_ctrl_length,
    input  logic [2:0]            acc_wr_ctrl_size,
    output logic                  acc_wr_ctrl_ready,
    // shared DMA request
    output logic                  dma_ctrl_valid,
    output logic                  dma_ctrl_write,
    output logic [LEN_WIDTH-1:0]  dma_ctrl_index,
    output logic [LEN_WIDTH-1:0]  dma_ctrl_length,
    output logic [2:0]            dma_ctrl_size,
    input  logic                  dma_ctrl_ready,
    // read data channel
    input  logic                  dma_rd_chnl_valid,
    input  logic [DATA_WIDTH-1:0] dma_rd_chnl_data,
    output logic                  dma_rd_chnl_ready,
    output logic                  acc_rd_chnl_valid,
    output logic [DATA_WIDTH-1:0] acc_rd_chnl_data,
    input  logic                  acc_rd_chnl_ready,
    // write data channel
    input  logic                  acc_wr_chnl_valid,
    input  logic [DATA_WIDTH-1:0] acc_wr_chnl_data,
    output logic                  acc_wr_chnl_ready,
    output logic                  dma_wr_chnl_valid,
    output logic [DATA_WIDTH-1:0] dma_wr_chnl_data,
    input  logic                  dma_wr_chnl_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_XFER = 2'd2,
        WR_XFER = 2'd3
    } state_t;

    state_t               state;
    logic                 last_grant_wr;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 grant_rd;
    logic                 grant_wr;
    logic                 in_rd;
    logic                 in_wr;
    logic                 rd_fire;
    logic                 wr_fire;

    // Round-robin grant, only evaluated in IDLE; a tie goes to the side not granted last
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE) begin
            if (acc_rd_ctrl_valid && (!acc_wr_ctrl_valid || last_grant_wr)) begin
                grant_rd = 1'b1;
            end else if (acc_wr_ctrl_valid) begin
                grant_wr = 1'b1;
            end
        end
    end

    assign acc_rd_ctrl_ready = grant_rd;
    assign acc_wr_ctrl_ready = grant_wr;

    // Data channel gating: only the channel matching the active transfer is connected
    always_comb begin
        in_rd             = (state == RD_XFER);
        in_wr             = (state == WR_XFER);
        acc_rd_chnl_valid = in_rd & dma_rd_chnl_valid;
        dma_rd_chnl_ready = in_rd & acc_rd_chnl_ready;
        acc_rd_chnl_data  = in_rd ? dma_rd_chnl_data : '0;
        dma_wr_chnl_valid = in_wr & acc_wr_chnl_valid;
        acc_wr_chnl_ready = in_wr & dma_wr_chnl_ready;
        dma_wr_chnl_data  = in_wr ? acc_wr_chnl_data : '0;
        rd_fire           = in_rd & dma_rd_chnl_valid & acc_rd_chnl_ready;
        wr_fire           = in_wr & acc_wr_chnl_valid & dma_wr_chnl_ready;
    end

    // Transaction FSM with registered DMA request fields, beat counter and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant_wr   <= 1'b1;
            beat_cnt        <= '0;
            dma_ctrl_valid  <= 1'b0;
            dma_ctrl_write  <= 1'b0;
            dma_ctrl_index  <= '0;
            dma_ctrl_length <= '0;
            dma_ctrl_size   <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd || grant_wr) begin
                        state          <= REQ;
                        busy           <= 1'b1;
                        dma_ctrl_valid <= 1'b1;
                        dma_ctrl_write <= grant_wr;
                        last_grant_wr  <= grant_wr;
                        if (grant_wr) begin
                            dma_ctrl_index  <= acc_wr_ctrl_index;
                            dma_ctrl_length <= acc_wr_ctrl_length;
                            dma_ctrl_size   <= acc_wr_ctrl_size;
                            beat_cnt        <= acc_wr_ctrl_length;
                        end else begin
                            dma_ctrl_index  <= acc_rd_ctrl_index;
                            dma_ctrl_length <= acc_rd_ctrl_length;
                            dma_ctrl_size   <= acc_rd_ctrl_size;
                            beat_cnt        <= acc_rd_ctrl_length;
                        end
                    end
                end
                REQ: begin
                    if (dma_ctrl_ready) begin
                        dma_ctrl_valid <= 1'b0;
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (dma_ctrl_write) begin
                            state <= WR_XFER;
                        end else begin
                            state <= RD_XFER;
                        end
                    end
                end
                RD_XFER: begin
                    if (rd_fire) begin
                        beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                        if (beat_cnt == LEN_WIDTH'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                WR_XFER: begin
                    if (wr_fire) begin
                        beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                        if (beat_cnt == LEN_WIDTH'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dma_scheduler.sv
// Directed testbench for mac_dma_scheduler: reset, single read, zero-length
// write, request/data backpressure, reset mid-transfer and round-robin ties.
module tb_mac_dma_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 32;

    logic          clk;
    logic          rst;
    logic          acc_rd_ctrl_valid;
    logic [LW-1:0] acc_rd_ctrl_index;
    logic [LW-1:0] acc_rd_ctrl_length;
    logic [2:0]    acc_rd_ctrl_size;
    logic          acc_rd_ctrl_ready;
    logic          acc_wr_ctrl_valid;
    logic [LW-1:0] acc_wr_ctrl_index;
    logic [LW-1:0] acc_wr_ctrl_length;
    logic [2:0]    acc_wr_ctrl_size;
    logic          acc_wr_ctrl_ready;
    logic          dma_ctrl_valid;
    logic          dma_ctrl_write;
    logic [LW-1:0] dma_ctrl_index;
    logic [LW-1:0] dma_ctrl_length;
    logic [2:0]    dma_ctrl_size;
    logic          dma_ctrl_ready;
    logic          dma_rd_chnl_valid;
    logic [DW-1:0] dma_rd_chnl_data;
    logic          dma_rd_chnl_ready;
    logic          acc_rd_chnl_valid;
    logic [DW-1:0] acc_rd_chnl_data;
    logic          acc_rd_chnl_ready;
    logic          acc_wr_chnl_valid;
    logic [DW-1:0] acc_wr_chnl_data;
    logic          acc_wr_chnl_ready;
    logic          dma_wr_chnl_valid;
    logic [DW-1:0] dma_wr_chnl_data;
    logic          dma_wr_chnl_ready;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    mac_dma_scheduler #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .acc_rd_ctrl_valid(acc_rd_ctrl_valid), .acc_rd_ctrl_index(acc_rd_ctrl_index),
        .acc_rd_ctrl_length(acc_rd_ctrl_length), .acc_rd_ctrl_size(acc_rd_ctrl_size),
        .acc_rd_ctrl_ready(acc_rd_ctrl_ready),
        .acc_wr_ctrl_valid(acc_wr_ctrl_valid), .acc_wr_ctrl_index(acc_wr_ctrl_index),
        .acc_wr_ctrl_length(acc_wr_ctrl_length), .acc_wr_ctrl_size(acc_wr_ctrl_size),
        .acc_wr_ctrl_ready(acc_wr_ctrl_ready),
        .dma_ctrl_valid(dma_ctrl_valid), .dma_ctrl_write(dma_ctrl_write),
        .dma_ctrl_index(dma_ctrl_index), .dma_ctrl_length(dma_ctrl_length),
        .dma_ctrl_size(dma_ctrl_size), .dma_ctrl_ready(dma_ctrl_ready),
        .dma_rd_chnl_valid(dma_rd_chnl_valid), .dma_rd_chnl_data(dma_rd_chnl_data),
        .dma_rd_chnl_ready(dma_rd_chnl_ready),
        .acc_rd_chnl_valid(acc_rd_chnl_valid), .acc_rd_chnl_data(acc_rd_chnl_data),
        .acc_rd_chnl_ready(acc_rd_chnl_ready),
        .acc_wr_chnl_valid(acc_wr_chnl_valid), .acc_wr_chnl_data(acc_wr_chnl_data),
        .acc_wr_chnl_ready(acc_wr_chnl_ready),
        .dma_wr_chnl_valid(dma_wr_chnl_valid), .dma_wr_chnl_data(dma_wr_chnl_data),
        .dma_wr_chnl_ready(dma_wr_chnl_ready),
        .busy(busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input drive point)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All outputs at their idle/reset values
    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},       64'(busy), 64'd0);
        chk({tag, ".ctrl_valid"}, 64'(dma_ctrl_valid), 64'd0);
        chk({tag, ".rd_chnl_rdy"}, 64'(dma_rd_chnl_ready), 64'd0);
        chk({tag, ".rd_chnl_vld"}, 64'(acc_rd_chnl_valid), 64'd0);
        chk({tag, ".wr_chnl_rdy"}, 64'(acc_wr_chnl_ready), 64'd0);
        chk({tag, ".wr_chnl_vld"}, 64'(dma_wr_chnl_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        acc_rd_ctrl_valid = 0; acc_rd_ctrl_index = '0; acc_rd_ctrl_length = '0; acc_rd_ctrl_size = '0;
        acc_wr_ctrl_valid = 0; acc_wr_ctrl_index = '0; acc_wr_ctrl_length = '0; acc_wr_ctrl_size = '0;
        dma_ctrl_ready = 0;
        dma_rd_chnl_valid = 0; dma_rd_chnl_data = '0; acc_rd_chnl_ready = 0;
        acc_wr_chnl_valid = 0; acc_wr_chnl_data = '0; dma_wr_chnl_ready = 0;

        // ---- reset values ----
        tick(); tick();
        #1;
        chk_idle("rst");
        chk("rst.ctrl_write", 64'(dma_ctrl_write), 64'd0);
        chk("rst.ctrl_index", 64'(dma_ctrl_index), 64'd0);
        chk("rst.ctrl_length", 64'(dma_ctrl_length), 64'd0);
        chk("rst.ctrl_size", 64'(dma_ctrl_size), 64'd0);
        chk("rst.rd_ctrl_rdy", 64'(acc_rd_ctrl_ready), 64'd0);
        chk("rst.wr_ctrl_rdy", 64'(acc_wr_ctrl_ready), 64'd0);
        tick();
        rst = 1'b0;

        // ---- single read: index 0x100, length 3, size 2 ----
        tick();
        acc_rd_ctrl_valid = 1; acc_rd_ctrl_index = 32'h100; acc_rd_ctrl_length = 3; acc_rd_ctrl_size = 2;
        dma_ctrl_ready = 1;
        #1;
        chk("rd.accept", 64'(acc_rd_ctrl_ready), 64'd1);
        chk("rd.wr_not_accept", 64'(acc_wr_ctrl_ready), 64'd0);
        chk("rd.ctrl_valid_pre", 64'(dma_ctrl_valid), 64'd0);
        tick();
        acc_rd_ctrl_valid = 0;
        #1;
        chk("rd.ctrl_valid", 64'(dma_ctrl_valid), 64'd1);
        chk("rd.ctrl_write", 64'(dma_ctrl_write), 64'd0);
        chk("rd.ctrl_index", 64'(dma_ctrl_index), 64'h100);
        chk("rd.ctrl_length", 64'(dma_ctrl_length), 64'd3);
        chk("rd.ctrl_size", 64'(dma_ctrl_size), 64'd2);
        chk("rd.busy", 64'(busy), 64'd1);
        tick();
        dma_rd_chnl_valid = 1; dma_rd_chnl_data = 32'hA; acc_rd_chnl_ready = 1;
        acc_wr_chnl_valid = 1; dma_wr_chnl_ready = 1;
        #1;
        chk("rd.ctrl_valid_drop", 64'(dma_ctrl_valid), 64'd0);
        chk("rd.beat0_vld", 64'(acc_rd_chnl_valid), 64'd1);
        chk("rd.beat0_data", 64'(acc_rd_chnl_data), 64'hA);
        chk("rd.beat0_rdy", 64'(dma_rd_chnl_ready), 64'd1);
        chk("rd.wr_gated_rdy", 64'(acc_wr_chnl_ready), 64'd0);
        chk("rd.wr_gated_vld", 64'(dma_wr_chnl_valid), 64'd0);
        tick();
        dma_rd_chnl_data = 32'hB;
        #1;
        chk("rd.beat1_data", 64'(acc_rd_chnl_data), 64'hB);
        chk("rd.beat1_busy", 64'(busy), 64'd1);
        tick();
        dma_rd_chnl_data = 32'hC;
        #1;
        chk("rd.beat2_data", 64'(acc_rd_chnl_data), 64'hC);
        chk("rd.beat2_busy", 64'(busy), 64'd1);
        tick();
        dma_rd_chnl_data = 32'hD;
        #1;
        chk_idle("rd.done");
        chk("rd.stray_data", 64'(acc_rd_chnl_data), 64'd0);
        tick();
        dma_rd_chnl_valid = 0; acc_rd_chnl_ready = 0;

        // ---- zero-length write: index 0x300, size 3 ----
        acc_wr_ctrl_valid = 1; acc_wr_ctrl_index = 32'h300; acc_wr_ctrl_length = 0; acc_wr_ctrl_size = 3;
        #1;
        chk("zw.accept", 64'(acc_wr_ctrl_ready), 64'd1);
        chk("zw.rd_not_accept", 64'(acc_rd_ctrl_ready), 64'd0);
        tick();
        acc_wr_ctrl_valid = 0;
        #1;
        chk("zw.ctrl_valid", 64'(dma_ctrl_valid), 64'd1);
        chk("zw.ctrl_write", 64'(dma_ctrl_write), 64'd1);
        chk("zw.ctrl_length", 64'(dma_ctrl_length), 64'd0);
        chk("zw.ctrl_index", 64'(dma_ctrl_index), 64'h300);
        chk("zw.req_wr_rdy", 64'(acc_wr_chnl_ready), 64'd0);
        tick();
        #1;
        chk_idle("zw.done");
        tick();
        acc_wr_chnl_valid = 0; dma_wr_chnl_ready = 0;

        // ---- backpressure: write index 0x400, length 2, size 1 ----
        acc_wr_ctrl_valid = 1; acc_wr_ctrl_index = 32'h400; acc_wr_ctrl_length = 2; acc_wr_ctrl_size = 1;
        dma_ctrl_ready = 0;
        #1;
        chk("bp.accept", 64'(acc_wr_ctrl_ready), 64'd1);
        tick();
        acc_wr_ctrl_valid = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dma_ctrl_ready = 1;
            #1;
            chk($sformatf("bp.req%0d.valid", i), 64'(dma_ctrl_valid), 64'd1);
            chk($sformatf("bp.req%0d.write", i), 64'(dma_ctrl_write), 64'd1);
            chk($sformatf("bp.req%0d.index", i), 64'(dma_ctrl_index), 64'h400);
            chk($sformatf("bp.req%0d.length", i), 64'(dma_ctrl_length), 64'd2);
            chk($sformatf("bp.req%0d.size", i), 64'(dma_ctrl_size), 64'd1);
            tick();
        end
        // write beats with DMA ready pattern 0,1,0,1: beats move only on ready
        acc_wr_chnl_valid = 1; acc_wr_chnl_data = 32'h11; dma_wr_chnl_ready = 0;
        #1;
        chk("bp.w0.ctrl_valid", 64'(dma_ctrl_valid), 64'd0);
        chk("bp.w0.rdy", 64'(acc_wr_chnl_ready), 64'd0);
        chk("bp.w0.vld", 64'(dma_wr_chnl_valid), 64'd1);
        chk("bp.w0.data", 64'(dma_wr_chnl_data), 64'h11);
        chk("bp.w0.rd_gated", 64'(dma_rd_chnl_ready), 64'd0);
        tick();
        dma_wr_chnl_ready = 1;
        #1;
        chk("bp.w1.rdy", 64'(acc_wr_chnl_ready), 64'd1);
        tick();
        acc_wr_chnl_data = 32'h22; dma_wr_chnl_ready = 0;
        #1;
        chk("bp.w2.busy", 64'(busy), 64'd1);
        chk("bp.w2.data", 64'(dma_wr_chnl_data), 64'h22);
        chk("bp.w2.rdy", 64'(acc_wr_chnl_ready), 64'd0);
        tick();
        dma_wr_chnl_ready = 1;
        #1;
        chk("bp.w3.busy", 64'(busy), 64'd1);
        chk("bp.w3.rdy", 64'(acc_wr_chnl_ready), 64'd1);
        tick();
        #1;
        chk_idle("bp.done");
        tick();
        acc_wr_chnl_valid = 0; dma_wr_chnl_ready = 0;

        // ---- reset during read transfer: index 0x500, length 4 ----
        acc_rd_ctrl_valid = 1; acc_rd_ctrl_index = 32'h500; acc_rd_ctrl_length = 4; acc_rd_ctrl_size = 2;
        #1;
        chk("rr.accept", 64'(acc_rd_ctrl_ready), 64'd1);
        tick();
        acc_rd_ctrl_valid = 0;
        tick();
        dma_rd_chnl_valid = 1; dma_rd_chnl_data = 32'h55; acc_rd_chnl_ready = 1;
        tick();
        #1;
        chk("rr.beat2_rdy", 64'(dma_rd_chnl_ready), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("rr.async");
        chk("rr.ctrl_length", 64'(dma_ctrl_length), 64'd0);
        tick();
        dma_rd_chnl_valid = 0; acc_rd_chnl_ready = 0;
        tick();
        rst = 1'b0;

        // ---- ties after reset: read, then write, then read ----
        tick();
        acc_rd_ctrl_valid = 1; acc_rd_ctrl_index = 32'h10; acc_rd_ctrl_length = 1; acc_rd_ctrl_size = 2;
        acc_wr_ctrl_valid = 1; acc_wr_ctrl_index = 32'h20; acc_wr_ctrl_length = 1; acc_wr_ctrl_size = 2;
        dma_ctrl_ready = 1;
        dma_rd_chnl_valid = 1; dma_rd_chnl_data = 32'h77; acc_rd_chnl_ready = 1;
        acc_wr_chnl_valid = 1; acc_wr_chnl_data = 32'h88; dma_wr_chnl_ready = 1;
        #1;
        chk("tie1.rd_rdy", 64'(acc_rd_ctrl_ready), 64'd1);
        chk("tie1.wr_rdy", 64'(acc_wr_ctrl_ready), 64'd0);
        tick();
        #1;
        chk("tie1.ctrl_write", 64'(dma_ctrl_write), 64'd0);
        chk("tie1.ctrl_index", 64'(dma_ctrl_index), 64'h10);
        chk("tie1.pend_rd_rdy", 64'(acc_rd_ctrl_ready), 64'd0);
        chk("tie1.pend_wr_rdy", 64'(acc_wr_ctrl_ready), 64'd0);
        tick();
        #1;
        chk("tie1.beat_data", 64'(acc_rd_chnl_data), 64'h77);
        tick();
        #1;
        chk("tie2.busy", 64'(busy), 64'd0);
        chk("tie2.wr_rdy", 64'(acc_wr_ctrl_ready), 64'd1);
        chk("tie2.rd_rdy", 64'(acc_rd_ctrl_ready), 64'd0);
        tick();
        #1;
        chk("tie2.ctrl_write", 64'(dma_ctrl_write), 64'd1);
        chk("tie2.ctrl_index", 64'(dma_ctrl_index), 64'h20);
        tick();
        #1;
        chk("tie2.beat_data", 64'(dma_wr_chnl_data), 64'h88);
        tick();
        #1;
        chk("tie3.rd_rdy", 64'(acc_rd_ctrl_ready), 64'd1);
        chk("tie3.wr_rdy", 64'(acc_wr_ctrl_ready), 64'd0);
        acc_rd_ctrl_valid = 0; acc_wr_ctrl_valid = 0;
        tick();
        #1;
        chk_idle("tie3.no_grant");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
